// File: rtl/card_disp_pkg.sv
// rtl/card_disp_pkg.sv - shared types and card-to-segment encoding for the card display bank
// Purpose: channel state enum, blank pattern constant and card code encoder.
// Ports: none (package).
package card_disp_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      SHOW  = 2'd1,
      BLINK = 2'd2
   } chan_state_t;

   // Active-low segments ordered {g,f,e,d,c,b,a}; all ones turns every segment off.
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   function automatic logic [6:0] card_enc(logic [3:0] code);
      logic [6:0] seg;
      case (code)
         4'd1:    seg = 7'b0001000; // A
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
         4'd10:   seg = 7'b1000000; // shown as 0
         4'd11:   seg = 7'b1100001; // J
         4'd12:   seg = 7'b0011000; // Q
         4'd13:   seg = 7'b0001001; // K
         default: seg = SEG_BLANK;  // 0, 14, 15
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/card_channel.sv
// rtl/card_channel.sv - one display channel: code register, EMPTY/SHOW/BLINK FSM, blink counter
// Purpose: holds a card code and produces its registered segment pattern.
// Ports:
//   clk, resetb        clock, async active-low reset
//   load, card_in      load strobe and 4-bit card code
//   clear              synchronous clear (wins over load)
//   blink_en           global blink enable
//   blink_tick         shared half-period tick
//   pat_next           pattern that pat takes on the next edge
//   pat                registered displayed pattern
//   blink_next         channel will be in BLINK after the next edge
module card_channel
   import card_disp_pkg::*;
#(
   parameter int BLINK_HALVES = 6
) (
   input  logic       clk,
   input  logic       resetb,
   input  logic       load,
   input  logic [3:0] card_in,
   input  logic       clear,
   input  logic       blink_en,
   input  logic       blink_tick,
   output logic [6:0] pat_next,
   output logic [6:0] pat,
   output logic       blink_next
);

   localparam int  REM_W     = (BLINK_HALVES < 2) ? 1 : $clog2(BLINK_HALVES + 1);
   localparam bit  CAN_BLINK = (BLINK_HALVES > 0);
   localparam logic [REM_W-1:0] REM_INIT = REM_W'(BLINK_HALVES);

   chan_state_t      state_q, state_d;
   logic [3:0]       code_q, code_d;
   logic [REM_W-1:0] rem_q, rem_d;

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state_q <= EMPTY;
         code_q  <= 4'd0;
         rem_q   <= '0;
         pat     <= SEG_BLANK;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         rem_q   <= rem_d;
         pat     <= pat_next;
      end
   end

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      rem_d   = rem_q;
      if (clear) begin
         state_d = EMPTY;
         code_d  = 4'd0;
         rem_d   = '0;
      end else if (load) begin
         // A load restarts the blink count and swallows a coincident tick.
         code_d = card_in;
         rem_d  = '0;
         if (card_in == 4'd0) begin
            state_d = EMPTY;
         end else if (blink_en && CAN_BLINK) begin
            state_d = BLINK;
            rem_d   = REM_INIT;
         end else begin
            state_d = SHOW;
         end
      end else if (state_q == BLINK) begin
         if (!blink_en) begin
            state_d = SHOW;
            rem_d   = '0;
         end else if (blink_tick) begin
            rem_d = rem_q - REM_W'(1);
            if (rem_q == REM_W'(1)) begin
               state_d = SHOW;
            end
         end
      end
   end

   // Pattern is derived from next-state values so hex_out and the scan bus
   // both reflect a load exactly one cycle later.
   always_comb begin
      pat_next = SEG_BLANK;
      case (state_d)
         EMPTY:   pat_next = SEG_BLANK;
         SHOW:    pat_next = card_enc(code_d);
         BLINK:   pat_next = rem_d[0] ? SEG_BLANK : card_enc(code_d);
         default: pat_next = SEG_BLANK;
      endcase
   end

   assign blink_next = (state_d == BLINK);

endmodule

// File: rtl/card7seg_bank.sv
// rtl/card7seg_bank.sv - N-channel card 7-segment driver with blink and scanned shared bus
// Purpose: per-channel parallel segment buses plus one multiplexed scan bus.
// Ports:
//   clk, resetb   clock, async active-low reset
//   load          per-channel load strobes
//   card_in       card codes, channel i at [4i+3:4i]
//   clear         synchronous clear of all channels
//   blink_en      global blink enable
//   hex_out       active-low segments, channel i at [7i+6:7i]
//   scan_seg      segments of the scanned channel
//   scan_an       active-low one-hot digit enable
//   busy          any channel blinking
module card7seg_bank
   import card_disp_pkg::*;
#(
   parameter int N_CH         = 6,
   parameter int BLINK_DIV    = 25_000_000,
   parameter int BLINK_HALVES = 6,
   parameter int SCAN_DIV     = 50_000
) (
   input  logic              clk,
   input  logic              resetb,
   input  logic [N_CH-1:0]   load,
   input  logic [4*N_CH-1:0] card_in,
   input  logic              clear,
   input  logic              blink_en,
   output logic [7*N_CH-1:0] hex_out,
   output logic [6:0]        scan_seg,
   output logic [N_CH-1:0]   scan_an,
   output logic              busy
);

   localparam int BW    = $clog2(BLINK_DIV);
   localparam int SW    = $clog2(SCAN_DIV);
   localparam int IDX_W = (N_CH < 2) ? 1 : $clog2(N_CH);

   logic [BW-1:0]    blink_cnt;
   logic [SW-1:0]    scan_cnt;
   logic [IDX_W-1:0] scan_idx, scan_idx_d;
   logic             blink_tick, scan_tick;
   logic [6:0]       pat_next_a [N_CH];
   logic [N_CH-1:0]  blink_next_v;
   logic [N_CH-1:0]  scan_an_d;

   assign blink_tick = (blink_cnt == BW'(BLINK_DIV - 1));
   assign scan_tick  = (scan_cnt == SW'(SCAN_DIV - 1));

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic [6:0] pat;
      card_channel #(.BLINK_HALVES(BLINK_HALVES)) u_ch (
         .clk        (clk),
         .resetb     (resetb),
         .load       (load[i]),
         .card_in    (card_in[4*i +: 4]),
         .clear      (clear),
         .blink_en   (blink_en),
         .blink_tick (blink_tick),
         .pat_next   (pat_next_a[i]),
         .pat        (pat),
         .blink_next (blink_next_v[i])
      );
      assign hex_out[7*i +: 7] = pat;
   end

   always_comb begin
      scan_idx_d = scan_idx;
      if (scan_tick) begin
         scan_idx_d = (scan_idx == IDX_W'(N_CH - 1)) ? '0 : scan_idx + IDX_W'(1);
      end
      scan_an_d = ~(N_CH'(1) << scan_idx_d);
   end

   // Segments and enable are loaded from the same next index on the same edge,
   // so a digit is never enabled with another digit's segments.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         blink_cnt <= '0;
         scan_cnt  <= '0;
         scan_idx  <= '0;
         scan_seg  <= SEG_BLANK;
         scan_an   <= ~N_CH'(1);
         busy      <= 1'b0;
      end else begin
         blink_cnt <= blink_tick ? '0 : blink_cnt + BW'(1);
         scan_cnt  <= scan_tick ? '0 : scan_cnt + SW'(1);
         scan_idx  <= scan_idx_d;
         scan_seg  <= pat_next_a[scan_idx_d];
         scan_an   <= scan_an_d;
         busy      <= |blink_next_v;
      end
   end

endmodule
